// File: rtl/game_control_pkg.sv
// Shared state encodings and constants for the game sequencing FSM.
package game_ctrl_pkg;

   typedef enum logic [3:0] {
      S_INIT          = 4'd0,
      S_IDLE          = 4'd1,
      S_GEN_MOVE      = 4'd2,
      S_CHECK_COLLIDE = 4'd3,
      S_APPLY_LINK    = 4'd4,
      S_MOVE_ENEMIES  = 4'd5,
      S_DRAW_MAP      = 4'd6,
      S_DRAW_LINK     = 4'd7,
      S_DRAW_ENEMIES  = 4'd8
   } state_t;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   localparam int unsigned TIMER_W = 20;

endpackage

// File: rtl/game_control_timer.sv
// Shared state-dwell counter: cleared on state entry, compared against a per-state limit.
module ctrl_timer
   import game_ctrl_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [TIMER_W-1:0] limit,
   output logic               hit,
   output logic               first
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + 1'b1;
   end

   assign hit   = (count == limit);
   assign first = (count == '0);

endmodule

// File: rtl/game_control.sv
// Top-level game frame sequencer: phase strobes, draw watchdogs, frame counter.
module game_control
   import game_ctrl_pkg::*;
#(
   parameter int unsigned INIT_CYCLES    = 2,
   parameter int unsigned COLLIDE_CYCLES = 2,
   parameter int unsigned DRAW_TIMEOUT   = 20'd131072,
   parameter int unsigned FC_W           = 16
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            pause,
   input  logic            idle_done,
   input  logic            draw_map_done,
   input  logic            draw_link_done,
   input  logic            draw_enemies_done,
   output logic            init,
   output logic            idle,
   output logic            gen_move,
   output logic            check_collide,
   output logic            apply_act_link,
   output logic            move_enemies,
   output logic            draw_map,
   output logic            draw_link,
   output logic            draw_enemies,
   output logic [FC_W-1:0] frame_count,
   output logic            timeout_err,
   output logic [3:0]      state_dbg
);

   localparam logic [TIMER_W-1:0] INIT_LIM    = TIMER_W'(INIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] COLLIDE_LIM = TIMER_W'(COLLIDE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DRAW_LIM    = TIMER_W'(DRAW_TIMEOUT - 1);

   state_t             state, next_state;
   logic               tmr_hit, tmr_first;
   logic [TIMER_W-1:0] tmr_limit;
   logic               timeout_set, frame_inc;

   ctrl_timer u_timer (
      .clock  (clock),
      .reset  (reset),
      .clear  (next_state != state),
      .enable (state != S_IDLE),
      .limit  (tmr_limit),
      .hit    (tmr_hit),
      .first  (tmr_first)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= S_INIT;
         frame_count <= '0;
         timeout_err <= OFF;
      end else begin
         state <= next_state;
         if (frame_inc)
            frame_count <= frame_count + 1'b1;
         if (timeout_set)
            timeout_err <= ON;
      end
   end

   // Draw states ignore done on their first cycle (stale done from the previous frame);
   // a real done always takes priority over the watchdog.
   always_comb begin
      next_state  = state;
      timeout_set = OFF;
      frame_inc   = OFF;
      tmr_limit   = DRAW_LIM;
      case (state)
         S_INIT: begin
            tmr_limit = INIT_LIM;
            if (tmr_hit) next_state = S_DRAW_MAP;
         end
         S_IDLE:
            if (idle_done && !pause) next_state = S_GEN_MOVE;
         S_GEN_MOVE:
            next_state = S_CHECK_COLLIDE;
         S_CHECK_COLLIDE: begin
            tmr_limit = COLLIDE_LIM;
            if (tmr_hit) next_state = S_APPLY_LINK;
         end
         S_APPLY_LINK:
            next_state = S_MOVE_ENEMIES;
         S_MOVE_ENEMIES:
            next_state = S_DRAW_MAP;
         S_DRAW_MAP:
            if (!tmr_first && draw_map_done) begin
               next_state = S_DRAW_LINK;
            end else if (tmr_hit) begin
               next_state  = S_DRAW_LINK;
               timeout_set = ON;
            end
         S_DRAW_LINK:
            if (!tmr_first && draw_link_done) begin
               next_state = S_DRAW_ENEMIES;
            end else if (tmr_hit) begin
               next_state  = S_DRAW_ENEMIES;
               timeout_set = ON;
            end
         S_DRAW_ENEMIES:
            if (!tmr_first && draw_enemies_done) begin
               next_state = S_IDLE;
               frame_inc  = ON;
            end else if (tmr_hit) begin
               next_state  = S_IDLE;
               frame_inc   = ON;
               timeout_set = ON;
            end
         default:
            next_state = S_INIT;
      endcase
   end

   always_comb begin
      init           = OFF;
      idle           = OFF;
      gen_move       = OFF;
      check_collide  = OFF;
      apply_act_link = OFF;
      move_enemies   = OFF;
      draw_map       = OFF;
      draw_link      = OFF;
      draw_enemies   = OFF;
      case (state)
         S_INIT:          init           = ON;
         S_IDLE:          idle           = ON;
         S_GEN_MOVE:      gen_move       = ON;
         S_CHECK_COLLIDE: check_collide  = ON;
         S_APPLY_LINK:    apply_act_link = ON;
         S_MOVE_ENEMIES:  move_enemies   = ON;
         S_DRAW_MAP:      draw_map       = ON;
         S_DRAW_LINK:     draw_link      = ON;
         S_DRAW_ENEMIES:  draw_enemies   = ON;
         default:         init           = OFF;
      endcase
   end

   assign state_dbg = state;

endmodule
